// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared definitions for the UART transmitter. Holds the bit
//                positions of the uart_ctrl_o fields and the control-register
//                reset value, which the register block also uses. It also
//                holds the transmit FSM state encoding and the parity helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef UART_DEFINE_VH
`define UART_DEFINE_VH
`define UART_CTRL_PEN_BIT   16
`define UART_CTRL_PODD_BIT  17
`define UART_CTRL_STOP2_BIT 18
`define UART_CTRL_EN_BIT    19
`define UART_CTRL_RST_VAL   32'h0000_0000
`endif

package uart_tx_pkg;

    localparam int unsigned c_PEN_BIT   = `UART_CTRL_PEN_BIT;
    localparam int unsigned c_PODD_BIT  = `UART_CTRL_PODD_BIT;
    localparam int unsigned c_STOP2_BIT = `UART_CTRL_STOP2_BIT;
    localparam int unsigned c_EN_BIT    = `UART_CTRL_EN_BIT;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit that goes on the line: even parity yields an even total
    // number of ones across data plus parity, odd parity an odd total.
    function automatic logic f_parity(input logic [7:0] i_data, input logic i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_baud_cnt
//  Description : Bit-period down-counter. A load sets the count to P-1
//                (P=0 behaves as P=1). The count then runs down to zero and
//                holds there. o_tick marks the last clock of the current bit.
//  Ports       : clk, rst_n   - clock, synchronous active-low reset
//                i_load       - restart the bit period
//                i_period     - bit period P in clocks
//                o_tick       - high while the count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_period == '0) ? '0 : (i_period - c_ONE);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter with one holding register and one shift
//                register. It supports 8 data bits, optional even/odd parity
//                and 1 or 2 stop bits. The baud divisor is programmable.
//                Frames run back-to-back when the holding register is
//                already full at the end of a stop bit.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                wr_data_flag  - one-cycle write strobe
//                data_reg_wr   - byte to transmit
//                uart_ctrl_o   - [DIV_W-1:0] divisor, [16] parity enable,
//                                [17] parity odd, [18] two stop, [19] enable
//                uart_txd      - serial line, idle high
//                tx_ok         - holding register empty
//                tx_busy       - a frame is being shifted
//                tx_overrun    - one-cycle pulse on a dropped write
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_data_flag,
    input  logic [7:0]  data_reg_wr,
    input  logic [31:0] uart_ctrl_o,
    output logic        uart_txd,
    output logic        tx_ok,
    output logic        tx_busy,
    output logic        tx_overrun
);

    state_t           r_state;
    logic             r_txd;
    logic             r_busy;
    logic             r_overrun;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_stop_idx;
    logic [DIV_W-1:0] r_div;
    logic             r_pen;
    logic             r_two_stop;
    logic             r_par_bit;

    logic             w_tick;
    logic             w_bit_end;
    logic             w_stop_done;
    logic             w_launch;
    logic             w_accept;
    logic             w_load;
    logic [DIV_W-1:0] w_period;
    logic             w_unused_ctrl;

    assign w_unused_ctrl = ^uart_ctrl_o[31:20];

    assign w_bit_end   = (r_state != ST_IDLE) && w_tick;
    assign w_stop_done = (r_state == ST_STOP) && w_tick && (!r_two_stop || r_stop_idx);

    // Launch happens from IDLE, or directly out of the final stop bit so
    // consecutive frames have no idle gap between them.
    assign w_launch = r_hold_full && uart_ctrl_o[c_EN_BIT] &&
                      ((r_state == ST_IDLE) || w_stop_done);
    assign w_accept = wr_data_flag && !r_hold_full;

    // A launching frame uses the live divisor. Bits inside a frame use the
    // latched copy, so changes to uart_ctrl_o mid-frame have no effect.
    assign w_period = w_launch ? uart_ctrl_o[DIV_W-1:0] : r_div;
    assign w_load   = w_launch || (w_bit_end && !w_stop_done);

    uart_tx_baud_cnt #(
        .DIV_W    (DIV_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_period (w_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_stop_idx  <= 1'b0;
            r_div       <= '0;
            r_pen       <= 1'b0;
            r_two_stop  <= 1'b0;
            r_par_bit   <= 1'b0;
        end else begin
            // Holding register. A strobe that finds it full is dropped, even
            // when a launch empties it at this same edge.
            r_overrun <= wr_data_flag && r_hold_full;
            if (w_accept) begin
                r_hold <= data_reg_wr;
            end
            if (w_launch) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end

            if (w_launch) begin
                r_shift    <= r_hold;
                r_div      <= uart_ctrl_o[DIV_W-1:0];
                r_pen      <= uart_ctrl_o[c_PEN_BIT];
                r_two_stop <= uart_ctrl_o[c_STOP2_BIT];
                r_par_bit  <= f_parity(r_hold, uart_ctrl_o[c_PODD_BIT]);
                r_bit_idx  <= 3'd0;
                r_stop_idx <= 1'b0;
                r_state    <= ST_START;
                r_txd      <= 1'b0;
                r_busy     <= 1'b1;
            end else if (w_bit_end) begin
                case (r_state)
                    ST_START: begin
                        r_state <= ST_DATA;
                        r_txd   <= r_shift[0];
                    end
                    ST_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (r_pen) begin
                                r_state <= ST_PARITY;
                                r_txd   <= r_par_bit;
                            end else begin
                                r_state <= ST_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP;
                        r_txd   <= 1'b1;
                    end
                    ST_STOP: begin
                        if (r_two_stop && !r_stop_idx) begin
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_txd      <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign uart_txd   = r_txd;
    assign tx_ok      = ~r_hold_full;
    assign tx_busy    = r_busy;
    assign tx_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. It runs a table of
//                single-frame vectors, then directed sequences for
//                back-to-back frames, overrun, disable/re-enable, reset in
//                the middle of a frame and a zero divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_data_flag;
    logic [7:0]  data_reg_wr;
    logic [31:0] uart_ctrl_o;
    logic        uart_txd;
    logic        tx_ok;
    logic        tx_busy;
    logic        tx_overrun;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.DIV_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data_flag (wr_data_flag),
        .data_reg_wr  (data_reg_wr),
        .uart_ctrl_o  (uart_ctrl_o),
        .uart_txd     (uart_txd),
        .tx_ok        (tx_ok),
        .tx_busy      (tx_busy),
        .tx_overrun   (tx_overrun)
    );

    always #5 clk = ~clk;

    // Frame bits are listed in line order, left to right: start, d0..d7,
    // [parity], stop(s), then padding ones.
    typedef struct {
        logic [15:0] div;
        logic        pen;
        logic        podd;
        logic        stop2;
        logic [7:0]  data;
        int          nbits;
        logic [0:11] bits;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] mk_ctrl(input logic [15:0] div, input logic pen,
                                            input logic podd, input logic stop2,
                                            input logic en);
        return {12'd0, en, stop2, podd, pen, div};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data_flag = 1'b1;
        data_reg_wr  = d;
        @(negedge clk);
        wr_data_flag = 1'b0;
    endtask

    // Checks line cycles k_from..k_to. Each call waits for the next negedge
    // first, so k_from is the cycle after the current one.
    task automatic sample_bits(input logic [0:23] b, input int p, input int k_from,
                               input int k_to, input string name);
        for (int k = k_from; k <= k_to; k++) begin
            @(negedge clk);
            chk($sformatf("%s txd k=%0d", name, k), {31'd0, uart_txd}, {31'd0, b[k / p]});
        end
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int          pe;
        logic [0:23] b;
        pe = (v.div == 16'd0) ? 1 : int'(v.div);
        b  = {v.bits, 12'hFFF};
        uart_ctrl_o = mk_ctrl(v.div, v.pen, v.podd, v.stop2, 1'b1);
        write_byte(v.data);
        chk({name, " tx_ok after strobe"}, {31'd0, tx_ok}, 32'd0);
        chk({name, " busy before launch"}, {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        chk({name, " start bit"}, {31'd0, uart_txd}, 32'd0);
        chk({name, " tx_ok at launch"}, {31'd0, tx_ok}, 32'd1);
        chk({name, " busy at launch"}, {31'd0, tx_busy}, 32'd1);
        sample_bits(b, pe, 1, v.nbits * pe - 1, name);
        @(negedge clk);
        chk({name, " idle txd"}, {31'd0, uart_txd}, 32'd1);
        chk({name, " idle busy"}, {31'd0, tx_busy}, 32'd0);
        chk({name, " idle tx_ok"}, {31'd0, tx_ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:23] b;
        bit          saw_low;
        vec_t        v0;

        vecs[0] = '{16'd4, 1'b0, 1'b0, 1'b0, 8'h55, 10, 12'b0_10101010_1_11};
        vecs[1] = '{16'd2, 1'b1, 1'b0, 1'b1, 8'h07, 12, 12'b0_11100000_1_1_1};
        vecs[2] = '{16'd3, 1'b1, 1'b1, 1'b0, 8'hA5, 11, 12'b0_10100101_1_1_1};
        vecs[3] = '{16'd1, 1'b0, 1'b0, 1'b1, 8'h80, 11, 12'b0_00000001_1_1_1};
        vecs[4] = '{16'd5, 1'b1, 1'b1, 1'b1, 8'h01, 12, 12'b0_10000000_0_1_1};
        vecs[5] = '{16'd1, 1'b1, 1'b0, 1'b0, 8'h00, 11, 12'b0_00000000_0_1_1};

        rst_n        = 1'b0;
        wr_data_flag = 1'b0;
        data_reg_wr  = 8'h00;
        uart_ctrl_o  = mk_ctrl(16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset txd", {31'd0, uart_txd}, 32'd1);
        chk("reset tx_ok", {31'd0, tx_ok}, 32'd1);
        chk("reset busy", {31'd0, tx_busy}, 32'd0);
        chk("reset overrun", {31'd0, tx_overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: 0xA5 then 0x3C three cycles later, divisor 4, 8N1.
        uart_ctrl_o = mk_ctrl(16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        b = {20'b0_10100101_1_0_00111100_1, 4'hF};
        write_byte(8'hA5);
        @(negedge clk);
        chk("b2b k0", {31'd0, uart_txd}, 32'd0);
        @(negedge clk);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'h3C;
        @(negedge clk);
        wr_data_flag = 1'b0;
        chk("b2b tx_ok after 2nd write", {31'd0, tx_ok}, 32'd0);
        sample_bits(b, 4, 3, 39, "b2b");
        chk("b2b tx_ok before launch", {31'd0, tx_ok}, 32'd0);
        sample_bits(b, 4, 40, 40, "b2b");
        chk("b2b tx_ok at 2nd launch", {31'd0, tx_ok}, 32'd1);
        sample_bits(b, 4, 41, 79, "b2b");
        @(negedge clk);
        chk("b2b idle txd", {31'd0, uart_txd}, 32'd1);
        chk("b2b idle busy", {31'd0, tx_busy}, 32'd0);

        // Overrun: divisor 8, third byte is dropped.
        uart_ctrl_o = mk_ctrl(16'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        b = {20'b0_10001000_1_0_01000100_1, 4'hF};
        write_byte(8'h11);
        @(negedge clk);
        chk("ovr k0", {31'd0, uart_txd}, 32'd0);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'h22;
        @(negedge clk);
        wr_data_flag = 1'b0;
        chk("ovr no pulse on accept", {31'd0, tx_overrun}, 32'd0);
        chk("ovr tx_ok held", {31'd0, tx_ok}, 32'd0);
        @(negedge clk);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'h33;
        @(negedge clk);
        wr_data_flag = 1'b0;
        chk("ovr pulse", {31'd0, tx_overrun}, 32'd1);
        @(negedge clk);
        chk("ovr pulse width", {31'd0, tx_overrun}, 32'd0);
        sample_bits(b, 8, 5, 159, "ovr");
        @(negedge clk);
        chk("ovr idle txd", {31'd0, uart_txd}, 32'd1);
        chk("ovr idle tx_ok", {31'd0, tx_ok}, 32'd1);

        // Disable mid-frame and change the divisor. The frame finishes at
        // divisor 2. The held byte waits, then a re-enable plus a strobe in
        // the same cycle launches it and drops the strobe.
        uart_ctrl_o = mk_ctrl(16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        b = {12'b0_11110000_1_11, 12'hFFF};
        write_byte(8'h0F);
        @(negedge clk);
        chk("dis k0", {31'd0, uart_txd}, 32'd0);
        uart_ctrl_o  = mk_ctrl(16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'hF0;
        @(negedge clk);
        wr_data_flag = 1'b0;
        chk("dis tx_ok held", {31'd0, tx_ok}, 32'd0);
        sample_bits(b, 2, 2, 19, "dis");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dis idle txd", {31'd0, uart_txd}, 32'd1);
            chk("dis idle busy", {31'd0, tx_busy}, 32'd0);
            chk("dis hold kept", {31'd0, tx_ok}, 32'd0);
        end
        uart_ctrl_o  = mk_ctrl(16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'h99;
        @(negedge clk);
        wr_data_flag = 1'b0;
        chk("reen overrun", {31'd0, tx_overrun}, 32'd1);
        chk("reen start", {31'd0, uart_txd}, 32'd0);
        chk("reen tx_ok", {31'd0, tx_ok}, 32'd1);
        b = {12'b0_00001111_1_11, 12'hFFF};
        sample_bits(b, 2, 1, 19, "reen");
        @(negedge clk);
        chk("reen idle txd", {31'd0, uart_txd}, 32'd1);
        chk("reen idle busy", {31'd0, tx_busy}, 32'd0);

        // Reset during the data bits, with a second byte already held.
        uart_ctrl_o = mk_ctrl(16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        write_byte(8'h00);
        @(negedge clk);
        wr_data_flag = 1'b1;
        data_reg_wr  = 8'hFF;
        @(negedge clk);
        wr_data_flag = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst mid data bit", {31'd0, uart_txd}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst txd", {31'd0, uart_txd}, 32'd1);
        chk("rst tx_ok", {31'd0, tx_ok}, 32'd1);
        chk("rst busy", {31'd0, tx_busy}, 32'd0);
        rst_n   = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) saw_low = 1'b1;
        end
        chk("rst no further bits", {31'd0, saw_low}, 32'd0);

        // Zero divisor behaves as one clock per bit.
        v0 = '{16'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 10, 12'b0_11111111_1_11};
        run_frame(v0, "div0");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DIV_W, default 16, sets the baud divisor width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port wr_data_flag, input, 1 bit: one-cycle write strobe for the UART data register.
REQ-005 Port data_reg_wr, input, 8 bits: byte to transmit; valid in the wr_data_flag cycle.
REQ-006 Port uart_ctrl_o, input, 32 bits: frame configuration, with fields as follows.
- [DIV_W-1:0]: baud divisor.
- [16]: parity enable.
- [17]: parity odd (0 = even).
- [18]: two stop bits.
- [19]: transmitter enable.
REQ-007 Port uart_txd, output, 1 bit: serial line; idle level is 1.
REQ-008 Port tx_ok, output, 1 bit: holding buffer empty, so a write is accepted.
REQ-009 Port tx_busy, output, 1 bit: a frame is being shifted (state is not IDLE).
REQ-010 Port tx_overrun, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-011 Buffering: one 8-bit holding register (hold, hold_full) plus one shift register.
- Accept: wr_data_flag=1 with hold_full=0 loads hold and sets hold_full at the next edge.
REQ-012 tx_ok SHALL equal !hold_full combinationally.
- tx_ok falls in the cycle after an accepted strobe.
REQ-013 Drop: wr_data_flag=1 with hold_full=1 keeps hold unchanged and pulses tx_overrun for exactly one cycle, registered at the next edge.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
- uart_txd is registered, and its level is fixed per state: IDLE 1, START 0, DATA shift[0] (LSB first), PARITY the parity bit, STOP 1.
REQ-015 Frame launch, IDLE->START: when hold_full=1 and uart_ctrl_o[19]=1, at that edge the FSM SHALL:
- move hold into the shift register and clear hold_full;
- latch divisor, parity enable, parity odd and stop count into frame registers.
REQ-016 Launch timing: a strobe at cycle N puts uart_txd=0 from cycle N+2 and returns tx_ok=1 from cycle N+2.
REQ-017 Bit period: each bit lasts exactly P clocks, where P = latched divisor, and a divisor of 0 is treated as 1.
- A down-counter reloads with P-1 on each bit entry and advances the state when it reaches 0.
REQ-018 Sequencing:
- START goes to DATA.
- DATA runs 8 bits, with a 3-bit index that wraps 7->0 on exit.
- DATA goes to PARITY if parity is enabled, else to STOP.
- STOP lasts 1 or 2 bit periods.
REQ-019 Parity bit = XOR of the 8 data bits, XOR parity odd; even parity gives an even count of ones including the parity bit.
REQ-020 End of STOP: go to START directly if hold_full=1 and enabled (no idle gap), else go to IDLE.
REQ-021 A write accepted during a frame SHALL be held and transmitted next, back-to-back.
REQ-022 Changes to uart_ctrl_o mid-frame SHALL NOT affect the frame in progress.
REQ-023 Disable: clearing enable mid-frame completes the current frame, then the FSM stays in IDLE.
- hold is retained while disabled and transmits when re-enabled.
REQ-024 Simultaneous strobe and launch in the same cycle:
- Launch reads the old hold, while hold_full=1 at that edge means the strobe is dropped with an overrun (the strobe sees tx_ok=0).

Reset
REQ-025 With rst_n=0 sampled at a rising edge, the block SHALL enter IDLE and set:
- uart_txd=1, tx_ok=1, tx_busy=0, tx_overrun=0;
- hold_full=0, counters=0, frame registers=0.
REQ-026 Reset mid-frame SHALL abort the frame at that edge, discard hold, and return uart_txd to 1 with no glitch to 0.

Structure
REQ-027 Bit positions of the uart_ctrl_o fields and the reset defaults SHALL be defined as macros in uart_define.v, shared with the register block.
REQ-028 The design is a single module; the bit-period counter MAY be the sub-module uart_baud_cnt (inputs: load, P; output: tick).

Verification
REQ-029 Basic frame: divisor=4, 8N1, enabled, write 0x55 -> the following, then tx_ok stays 1.
- uart_txd = 0,1,0,1,0,1,0,1,0,1, each level lasting 4 clocks, from cycle N+2.
- The frame lasts 40 clocks, then the line is idle.
REQ-030 Parity: divisor=2, even parity, 2 stop bits, write 0x07 -> the frame is start, 1,1,1,0,0,0,0,0, parity 1, stop 1,1, for 24 clocks total.
REQ-031 Back-to-back: write 0xA5 then, 3 cycles later, 0x3C -> the 0x3C start bit follows the last 0xA5 stop bit with 0 idle clocks.
- tx_ok is 0 from the second write until launch.
REQ-032 Overrun: with divisor=8, write 0x11, 0x22, 0x33 on consecutive accept opportunities during the first frame -> 0x11 and 0x22 are sent, and tx_overrun pulses once for 0x33.
REQ-033 Reset and zero divisor:
- Assert rst_n=0 in the middle of the DATA bits -> uart_txd=1 and tx_ok=1 at the next edge, with no further bits.
- Then divisor=0 with 0xFF -> a 10-clock frame.
